// File: rtl/core_ex_pkg.sv
// Shared definitions for the execute stage: ALU op and funct encodings, mult/div FSM states,
// and the EX/MEM register layout with its bubble value.
package core_ex_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ORI   = 2'b11;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
   typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

   typedef struct packed {
      logic        wb_reg_write;
      logic        wb_memtoreg;
      logic        mem_memread;
      logic        mem_memwrite;
      logic        mem_ll_mem;
      logic        mem_sc_mem;
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [4:0]  reg_dest;
   } em_t;

   localparam em_t EM_BUBBLE = '0;

   // r0 is hardwired zero, so a write to it never forwards.
   function automatic logic fwd_hit(input logic we, input logic [4:0] dest, input logic [4:0] src);
      return we && (dest != 5'd0) && (dest == src);
   endfunction

endpackage

// File: rtl/core_ex_stage_muldiv.sv
// Iterative radix-2 multiply / restoring divide with HI/LO; busy covers the issue cycle plus
// MD_CYCLES step cycles, results commit on the DONE edge, abort discards work without touching HI/LO.
module core_muldiv
   import core_ex_pkg::*;
#(
   parameter int MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  md_op_t      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        abort,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = $clog2(MD_CYCLES + 1);

   md_state_t   state, state_nx;
   logic [CW-1:0] count;
   logic [63:0] acc;
   logic [31:0] mcand;
   logic [31:0] dividend;
   md_op_t      op_q;
   logic        neg_a, neg_b, div0;
   logic        signed_op, is_mul;
   logic [32:0] mul_sum, div_trial;
   logic [63:0] mul_step, div_step, prod;
   logic [31:0] res_hi, res_lo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= MD_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         MD_IDLE: if (start && !abort) state_nx = MD_BUSY;
         MD_BUSY: begin
            if (abort)                                state_nx = MD_IDLE;
            else if (count == CW'(MD_CYCLES - 1))     state_nx = MD_DONE;
         end
         MD_DONE: state_nx = MD_IDLE;
         default: state_nx = MD_IDLE;
      endcase
   end

   always_comb begin
      busy = !rst && !abort && (((state == MD_IDLE) && start) || (state == MD_BUSY));
   end

   assign signed_op = (op == MD_MULT) || (op == MD_DIV);
   assign is_mul    = (op_q == MD_MULT) || (op_q == MD_MULTU);

   // acc = {upper, lower}: product accumulator / multiplier, or remainder / quotient-dividend.
   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
      mul_step  = {mul_sum, acc[31:1]};
      div_trial = {acc[63:32], acc[31]} - {1'b0, mcand};
      div_step  = div_trial[32] ? {acc[62:0], 1'b0} : {div_trial[31:0], acc[30:0], 1'b1};
   end

   always_comb begin
      prod = (neg_a ^ neg_b) ? (64'd0 - acc) : acc;
      if (is_mul) begin
         res_hi = prod[63:32];
         res_lo = prod[31:0];
      end else if (div0) begin
         res_hi = dividend;
         res_lo = 32'hFFFF_FFFF;
      end else begin
         res_lo = (neg_a ^ neg_b) ? (32'd0 - acc[31:0]) : acc[31:0];
         res_hi = neg_a ? (32'd0 - acc[63:32]) : acc[63:32];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         acc      <= '0;
         mcand    <= '0;
         dividend <= '0;
         op_q     <= MD_MULT;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         div0     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else if (!abort) begin
         case (state)
            MD_IDLE: if (start) begin
               op_q     <= op;
               neg_a    <= signed_op && a[31];
               neg_b    <= signed_op && b[31];
               acc      <= {32'd0, (signed_op && a[31]) ? (32'd0 - a) : a};
               mcand    <= (signed_op && b[31]) ? (32'd0 - b) : b;
               dividend <= a;
               div0     <= (b == 32'd0);
               count    <= '0;
            end
            MD_BUSY: begin
               acc   <= is_mul ? mul_step : div_step;
               count <= count + 1'b1;
            end
            MD_DONE: begin
               hi <= res_hi;
               lo <= res_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/core_ex_stage.sv
// Execute stage: operand forwarding, ALU, destination select, mult/div unit and the EX/MEM register.
// ex_stall holds upstream while mult/div works; stalled or flushed cycles load a bubble into EX/MEM.
module core_ex_stage
   import core_ex_pkg::*;
#(
   parameter int MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_wb_reg_write,
   input  logic        ex_wb_memtoreg,
   input  logic        ex_mem_memread,
   input  logic        ex_mem_memwrite,
   input  logic        ex_mem_ll_mem,
   input  logic        ex_mem_sc_mem,
   input  logic        ex_regdst,
   input  logic        ex_alusrc,
   input  logic [1:0]  ex_aluop,
   input  logic [31:0] ex_regread1,
   input  logic [31:0] ex_regread2,
   input  logic [31:0] ex_sign_extend,
   input  logic [4:0]  ex_reg_rs,
   input  logic [4:0]  ex_reg_rt,
   input  logic [4:0]  ex_reg_rd,
   input  logic        ex_flush,
   input  logic        fw_mem_reg_write,
   input  logic [4:0]  fw_mem_dest,
   input  logic [31:0] fw_mem_data,
   input  logic        fw_wb_reg_write,
   input  logic [4:0]  fw_wb_dest,
   input  logic [31:0] fw_wb_data,
   output logic        ex_stall,
   output logic        em_wb_reg_write,
   output logic        em_wb_memtoreg,
   output logic        em_mem_memread,
   output logic        em_mem_memwrite,
   output logic        em_mem_ll_mem,
   output logic        em_mem_sc_mem,
   output logic [31:0] em_alu_result,
   output logic [31:0] em_store_data,
   output logic [4:0]  em_reg_dest
);

   logic [31:0] fwd_rs, fwd_rt, op_b, alu_res;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic        alu_ok, is_md, md_busy;
   md_op_t      md_op;
   logic [31:0] md_hi, md_lo;
   em_t         em_d, em_q;

   assign funct = ex_sign_extend[5:0];
   assign shamt = ex_sign_extend[10:6];

   assign fwd_rs = fwd_hit(fw_mem_reg_write, fw_mem_dest, ex_reg_rs) ? fw_mem_data :
                   fwd_hit(fw_wb_reg_write,  fw_wb_dest,  ex_reg_rs) ? fw_wb_data  : ex_regread1;
   assign fwd_rt = fwd_hit(fw_mem_reg_write, fw_mem_dest, ex_reg_rt) ? fw_mem_data :
                   fwd_hit(fw_wb_reg_write,  fw_wb_dest,  ex_reg_rt) ? fw_wb_data  : ex_regread2;

   assign op_b = (ex_aluop == ALUOP_ORI) ? {16'h0, ex_sign_extend[15:0]} :
                 ex_alusrc ? ex_sign_extend : fwd_rt;

   always_comb begin
      alu_res = '0;
      alu_ok  = 1'b1;
      is_md   = 1'b0;
      md_op   = MD_MULT;
      case (ex_aluop)
         ALUOP_ADD: alu_res = fwd_rs + op_b;
         ALUOP_SUB: alu_res = fwd_rs - op_b;
         ALUOP_ORI: alu_res = fwd_rs | op_b;
         default: begin
            case (funct)
               FN_ADD, FN_ADDU: alu_res = fwd_rs + op_b;
               FN_SUB, FN_SUBU: alu_res = fwd_rs - op_b;
               FN_AND:  alu_res = fwd_rs & op_b;
               FN_OR:   alu_res = fwd_rs | op_b;
               FN_XOR:  alu_res = fwd_rs ^ op_b;
               FN_NOR:  alu_res = ~(fwd_rs | op_b);
               FN_SLT:  alu_res = {31'd0, $signed(fwd_rs) < $signed(op_b)};
               FN_SLTU: alu_res = {31'd0, fwd_rs < op_b};
               FN_SLL:  alu_res = fwd_rt << shamt;
               FN_SRL:  alu_res = fwd_rt >> shamt;
               FN_SRA:  alu_res = $unsigned($signed(fwd_rt) >>> shamt);
               FN_MFHI: alu_res = md_hi;
               FN_MFLO: alu_res = md_lo;
               FN_MULT:  begin is_md = 1'b1; md_op = MD_MULT;  end
               FN_MULTU: begin is_md = 1'b1; md_op = MD_MULTU; end
               FN_DIV:   begin is_md = 1'b1; md_op = MD_DIV;   end
               FN_DIVU:  begin is_md = 1'b1; md_op = MD_DIVU;  end
               default: alu_ok = 1'b0;
            endcase
         end
      endcase
   end

   core_muldiv #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
      .clk   (clk),
      .rst   (rst),
      .start (is_md),
      .op    (md_op),
      .a     (fwd_rs),
      .b     (fwd_rt),
      .abort (ex_flush),
      .busy  (md_busy),
      .hi    (md_hi),
      .lo    (md_lo)
   );

   assign ex_stall = md_busy;

   always_comb begin
      em_d              = EM_BUBBLE;
      em_d.wb_reg_write = ex_wb_reg_write && alu_ok && !is_md;
      em_d.wb_memtoreg  = ex_wb_memtoreg;
      em_d.mem_memread  = ex_mem_memread;
      em_d.mem_memwrite = ex_mem_memwrite;
      em_d.mem_ll_mem   = ex_mem_ll_mem;
      em_d.mem_sc_mem   = ex_mem_sc_mem;
      em_d.alu_result   = alu_res;
      em_d.store_data   = fwd_rt;
      em_d.reg_dest     = ex_regdst ? ex_reg_rd : ex_reg_rt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       em_q <= EM_BUBBLE;
      else if (ex_stall || ex_flush) em_q <= EM_BUBBLE;
      else                           em_q <= em_d;
   end

   assign em_wb_reg_write = em_q.wb_reg_write;
   assign em_wb_memtoreg  = em_q.wb_memtoreg;
   assign em_mem_memread  = em_q.mem_memread;
   assign em_mem_memwrite = em_q.mem_memwrite;
   assign em_mem_ll_mem   = em_q.mem_ll_mem;
   assign em_mem_sc_mem   = em_q.mem_sc_mem;
   assign em_alu_result   = em_q.alu_result;
   assign em_store_data   = em_q.store_data;
   assign em_reg_dest     = em_q.reg_dest;

endmodule

// File: tb/tb_core_ex_stage.sv
// Scoreboard bench for core_ex_stage: the driver queues the expected EX/MEM contents per cycle,
// a monitor pops and compares after each rising edge.
module tb_core_ex_stage;
   import core_ex_pkg::*;

   localparam int MDC = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_wb_reg_write, ex_wb_memtoreg, ex_mem_memread, ex_mem_memwrite;
   logic        ex_mem_ll_mem, ex_mem_sc_mem, ex_regdst, ex_alusrc;
   logic [1:0]  ex_aluop;
   logic [31:0] ex_regread1, ex_regread2, ex_sign_extend;
   logic [4:0]  ex_reg_rs, ex_reg_rt, ex_reg_rd;
   logic        ex_flush;
   logic        fw_mem_reg_write, fw_wb_reg_write;
   logic [4:0]  fw_mem_dest, fw_wb_dest;
   logic [31:0] fw_mem_data, fw_wb_data;
   logic        ex_stall;
   logic        em_wb_reg_write, em_wb_memtoreg, em_mem_memread, em_mem_memwrite;
   logic        em_mem_ll_mem, em_mem_sc_mem;
   logic [31:0] em_alu_result, em_store_data;
   logic [4:0]  em_reg_dest;

   core_ex_stage #(.MD_CYCLES(MDC)) dut (
      .clk(clk), .rst(rst),
      .ex_wb_reg_write(ex_wb_reg_write), .ex_wb_memtoreg(ex_wb_memtoreg),
      .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
      .ex_mem_ll_mem(ex_mem_ll_mem), .ex_mem_sc_mem(ex_mem_sc_mem),
      .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
      .ex_regread1(ex_regread1), .ex_regread2(ex_regread2), .ex_sign_extend(ex_sign_extend),
      .ex_reg_rs(ex_reg_rs), .ex_reg_rt(ex_reg_rt), .ex_reg_rd(ex_reg_rd),
      .ex_flush(ex_flush),
      .fw_mem_reg_write(fw_mem_reg_write), .fw_mem_dest(fw_mem_dest), .fw_mem_data(fw_mem_data),
      .fw_wb_reg_write(fw_wb_reg_write), .fw_wb_dest(fw_wb_dest), .fw_wb_data(fw_wb_data),
      .ex_stall(ex_stall),
      .em_wb_reg_write(em_wb_reg_write), .em_wb_memtoreg(em_wb_memtoreg),
      .em_mem_memread(em_mem_memread), .em_mem_memwrite(em_mem_memwrite),
      .em_mem_ll_mem(em_mem_ll_mem), .em_mem_sc_mem(em_mem_sc_mem),
      .em_alu_result(em_alu_result), .em_store_data(em_store_data), .em_reg_dest(em_reg_dest)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic chk;
      em_t  em;
   } rec_t;

   rec_t  exp_q[$];
   string name_q[$];
   int    checks   = 0;
   int    failures = 0;

   function automatic em_t act();
      em_t e;
      e.wb_reg_write = em_wb_reg_write;
      e.wb_memtoreg  = em_wb_memtoreg;
      e.mem_memread  = em_mem_memread;
      e.mem_memwrite = em_mem_memwrite;
      e.mem_ll_mem   = em_mem_ll_mem;
      e.mem_sc_mem   = em_mem_sc_mem;
      e.alu_result   = em_alu_result;
      e.store_data   = em_store_data;
      e.reg_dest     = em_reg_dest;
      return e;
   endfunction

   function automatic em_t mk(input logic rw, input logic [31:0] res, input logic [31:0] sd,
                              input logic [4:0] dest);
      em_t e = EM_BUBBLE;
      e.wb_reg_write = rw;
      e.alu_result   = res;
      e.store_data   = sd;
      e.reg_dest     = dest;
      return e;
   endfunction

   task automatic chk_em(input string nm, input em_t a, input em_t e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: em got %h expected %h", nm, a, e);
      end
   endtask

   task automatic chk1(input string nm, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, a, e);
      end
   endtask

   // Monitor: one record per driven cycle, compared just after the edge that loads it.
   initial begin
      rec_t  r;
      string n;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            n = name_q.pop_front();
            if (r.chk) chk_em(n, act(), r.em);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_ins(input logic [1:0] aluop, input logic alusrc, input logic regdst,
                          input logic rw, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
      ex_aluop = aluop; ex_alusrc = alusrc; ex_regdst = regdst; ex_wb_reg_write = rw;
      ex_regread1 = a; ex_regread2 = b; ex_sign_extend = imm;
      ex_reg_rs = rs; ex_reg_rt = rt; ex_reg_rd = rd;
      ex_wb_memtoreg = 1'b0; ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0;
      ex_mem_ll_mem = 1'b0; ex_mem_sc_mem = 1'b0;
   endtask

   task automatic fw_clear();
      fw_mem_reg_write = 1'b0; fw_mem_dest = 5'd0; fw_mem_data = 32'd0;
      fw_wb_reg_write  = 1'b0; fw_wb_dest  = 5'd0; fw_wb_data  = 32'd0;
   endtask

   // Inputs are already applied (just after a falling edge); check stall, queue expectation, advance.
   task automatic cycle(input logic chk, input em_t e, input string nm, input logic cs,
                        input logic es);
      rec_t r;
      #1;
      if (cs) chk1({nm, "_stall"}, ex_stall, es);
      r.chk = chk;
      r.em  = e;
      exp_q.push_back(r);
      name_q.push_back(nm);
      @(negedge clk);
   endtask

   task automatic rd_hilo(input string nm, input logic [31:0] lo, input logic [31:0] hi);
      set_ins(ALUOP_RTYPE, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, {26'd0, FN_MFLO}, 5'd0, 5'd0, 5'd4);
      cycle(1'b1, mk(1'b1, lo, 32'd0, 5'd4), {nm, "_mflo"}, 1'b1, 1'b0);
      set_ins(ALUOP_RTYPE, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, {26'd0, FN_MFHI}, 5'd0, 5'd0, 5'd4);
      cycle(1'b1, mk(1'b1, hi, 32'd0, 5'd4), {nm, "_mfhi"}, 1'b1, 1'b0);
   endtask

   task automatic md_issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      set_ins(ALUOP_RTYPE, 1'b0, 1'b1, 1'b1, a, b, {26'd0, fn}, 5'd1, 5'd2, 5'd9);
   endtask

   task automatic run_md(input string nm, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi);
      md_issue(fn, a, b);
      for (int i = 0; i < MDC + 1; i++) cycle(1'b1, EM_BUBBLE, {nm, "_bubble"}, 1'b1, 1'b1);
      cycle(1'b1, mk(1'b0, 32'd0, b, 5'd9), {nm, "_done"}, 1'b1, 1'b0);
      rd_hilo(nm, lo, hi);
   endtask

   initial begin
      em_t e;
      rst = 1'b1;
      ex_flush = 1'b0;
      fw_clear();
      md_issue(FN_MULT, 32'd5, 32'd6);
      repeat (3) @(negedge clk);
      #1;
      chk_em("reset_em", act(), EM_BUBBLE);
      chk1("reset_stall_with_md", ex_stall, 1'b0);
      @(negedge clk);
      set_ins(ALUOP_ADD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      rst = 1'b0;

      // MEM forwarding wins over WB; load-style controls pass through.
      set_ins(ALUOP_ADD, 1'b1, 1'b0, 1'b1, 32'h999, 32'h55, 32'd4, 5'd3, 5'd5, 5'd0);
      ex_mem_memread = 1'b1; ex_wb_memtoreg = 1'b1;
      fw_mem_reg_write = 1'b1; fw_mem_dest = 5'd3; fw_mem_data = 32'h10;
      fw_wb_reg_write  = 1'b1; fw_wb_dest  = 5'd3; fw_wb_data  = 32'h20;
      e = mk(1'b1, 32'h14, 32'h55, 5'd5);
      e.mem_memread = 1'b1; e.wb_memtoreg = 1'b1;
      cycle(1'b1, e, "fwd_mem_prio", 1'b1, 1'b0);

      // WB forwarding on rt feeds operand B and store data.
      set_ins(ALUOP_SUB, 1'b0, 1'b1, 1'b1, 32'h100, 32'h1, 32'd0, 5'd7, 5'd3, 5'd6);
      fw_mem_reg_write = 1'b0;
      cycle(1'b1, mk(1'b1, 32'hE0, 32'h20, 5'd6), "fwd_wb_rt", 1'b1, 1'b0);

      set_ins(ALUOP_ADD, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 32'd4, 5'd0, 5'd0, 5'd0);
      fw_mem_reg_write = 1'b1; fw_mem_dest = 5'd0; fw_mem_data = 32'hFF;
      fw_wb_reg_write  = 1'b1; fw_wb_dest  = 5'd0; fw_wb_data  = 32'hEE;
      cycle(1'b1, mk(1'b1, 32'd9, 32'd0, 5'd0), "fwd_r0", 1'b1, 1'b0);
      fw_clear();

      set_ins(ALUOP_RTYPE, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, {26'd0, FN_SLT}, 5'd1, 5'd2, 5'd8);
      cycle(1'b1, mk(1'b1, 32'd1, 32'd1, 5'd8), "slt", 1'b1, 1'b0);
      set_ins(ALUOP_RTYPE, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, {26'd0, FN_SLTU}, 5'd1, 5'd2, 5'd8);
      cycle(1'b1, mk(1'b1, 32'd0, 32'd1, 5'd8), "sltu", 1'b1, 1'b0);
      set_ins(ALUOP_RTYPE, 1'b0, 1'b1, 1'b1, 32'd0, 32'h8000_0000, 32'h0000_0103, 5'd1, 5'd2, 5'd8);
      cycle(1'b1, mk(1'b1, 32'hF800_0000, 32'h8000_0000, 5'd8), "sra4", 1'b1, 1'b0);
      set_ins(ALUOP_ORI, 1'b1, 1'b0, 1'b1, 32'h1234_0000, 32'd0, 32'hFFFF_8765, 5'd1, 5'd2, 5'd8);
      cycle(1'b1, mk(1'b1, 32'h1234_8765, 32'd0, 5'd2), "ori_zext", 1'b1, 1'b0);
      set_ins(ALUOP_RTYPE, 1'b0, 1'b1, 1'b1, 32'd5, 32'd6, 32'h0000_003F, 5'd1, 5'd2, 5'd8);
      cycle(1'b1, mk(1'b0, 32'd0, 32'd6, 5'd8), "undef_funct", 1'b1, 1'b0);

      run_md("mult", FN_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
      run_md("div", FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_md("divu0", FN_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);

      // Abort in the 10th busy cycle: HI/LO keep the divu-by-zero result.
      md_issue(FN_MULT, 32'd5, 32'd6);
      for (int i = 0; i < 10; i++) cycle(1'b1, EM_BUBBLE, "abort_pre", 1'b1, 1'b1);
      ex_flush = 1'b1;
      cycle(1'b1, EM_BUBBLE, "abort_flush", 1'b1, 1'b0);
      ex_flush = 1'b0;
      rd_hilo("abort_keep", 32'hFFFF_FFFF, 32'h1234_5678);
      run_md("mult_after_abort", FN_MULT, 32'd5, 32'd6, 32'd30, 32'd0);

      // Async reset while EX/MEM holds a live result.
      set_ins(ALUOP_ADD, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 32'd4, 5'd1, 5'd2, 5'd3);
      cycle(1'b1, mk(1'b1, 32'd9, 32'd0, 5'd2), "pre_rst_add", 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk_em("async_rst_em", act(), EM_BUBBLE);
      @(negedge clk);
      rst = 1'b0;

      // Async reset mid mult/div: no partial result, HI/LO cleared.
      md_issue(FN_MULTU, 32'd5, 32'd6);
      for (int i = 0; i < 6; i++) cycle(1'b1, EM_BUBBLE, "rst_md_busy", 1'b1, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("rst_md_stall", ex_stall, 1'b0);
      chk_em("rst_md_em", act(), EM_BUBBLE);
      @(negedge clk);
      rst = 1'b0;
      rd_hilo("rst_md_clear", 32'd0, 32'd0);

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
